// File: rtl/ram_arbiter.sv
// ram_arbiter
// Arbitrates a single-port synchronous RAM between an instruction fetch port
// and a load/store port. Sub-word stores are done as read-modify-write.
//
// Ports
//   iCLK, iRST_N           clock, asynchronous active-low reset
//   iIF_REQ, iIF_ADDR      fetch request (held until oIF_ACK), word address
//   oIF_ACK, oIF_DATA      fetch completion pulse, fetched word
//   iLS_REQ, iLS_WR        load/store request (held until oLS_ACK), 1 = store
//   iLS_SIZE, iLS_ADDR     00 byte, 01 half, 10 word, 11 illegal; byte address
//   iLS_WDATA              right-aligned store data
//   oLS_ACK, oLS_ERR       completion pulse, misaligned/illegal flag
//   oLS_RDATA              raw RAM word for loads
//   oRAM_CE/RD/WR          RAM strobes
//   oRAM_ADDR, oRAM_WDATA  RAM word address and write data
//   iRAM_DATA              RAM read data, valid the cycle after RD
//   oBUSY                  high whenever the FSM is not idle
module ram_arbiter (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iIF_REQ,
  input  logic [7:0]  iIF_ADDR,
  output logic        oIF_ACK,
  output logic [31:0] oIF_DATA,
  input  logic        iLS_REQ,
  input  logic        iLS_WR,
  input  logic [1:0]  iLS_SIZE,
  input  logic [9:0]  iLS_ADDR,
  input  logic [31:0] iLS_WDATA,
  output logic        oLS_ACK,
  output logic        oLS_ERR,
  output logic [31:0] oLS_RDATA,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [7:0]  oRAM_ADDR,
  output logic [31:0] oRAM_WDATA,
  input  logic [31:0] iRAM_DATA,
  output logic        oBUSY
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RESP  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state;
  logic        prefer_data;   // 1: data port wins a tie
  logic        cur_fetch;
  logic        cur_wr;
  logic [1:0]  cur_size;
  logic [1:0]  cur_lane;
  logic [31:0] cur_wdata;
  logic        if_ack;
  logic        ls_ack;
  logic        ls_err;
  logic        ram_ce;
  logic        ram_rd;
  logic        ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] if_data;
  logic [31:0] ls_rdata;
  logic        busy;

  logic        grant_data;
  logic        grant_fetch;
  logic        ls_illegal;
  logic        ls_resp;

  // Size/alignment legality of a data access.
  function automatic logic illegal_access(input logic [1:0] size,
                                          input logic [1:0] lane);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace the addressed byte/half lane of the old word with store data.
  function automatic logic [31:0] merge_word(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] m;
    m = old;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   m[7:0]   = wdata[7:0];
          2'b01:   m[15:8]  = wdata[7:0];
          2'b10:   m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) m[31:16] = wdata[15:0];
        else         m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  // Alternating arbitration: on a tie the side not served last wins.
  assign grant_data  = iLS_REQ && (!iIF_REQ || prefer_data);
  assign grant_fetch = iIF_REQ && !grant_data;
  assign ls_illegal  = illegal_access(iLS_SIZE, iLS_ADDR[1:0]);

  // The RAM word only becomes valid in the RESP cycle, so during the ACK
  // cycle the data outputs bypass straight from the RAM; afterwards the
  // captured copy holds until the next ACK.
  assign ls_resp    = ls_ack && (state == RESP);
  assign oIF_DATA   = if_ack  ? iRAM_DATA : if_data;
  assign oLS_RDATA  = ls_resp ? iRAM_DATA : ls_rdata;

  assign oIF_ACK    = if_ack;
  assign oLS_ACK    = ls_ack;
  assign oLS_ERR    = ls_err;
  assign oRAM_CE    = ram_ce;
  assign oRAM_RD    = ram_rd;
  assign oRAM_WR    = ram_wr;
  assign oRAM_ADDR  = ram_addr;
  assign oRAM_WDATA = ram_wdata;
  assign oBUSY      = busy;

  // Main FSM; strobes and acks are registered for the state being entered.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      prefer_data <= 1'b1;
      cur_fetch   <= 1'b0;
      cur_wr      <= 1'b0;
      cur_size    <= 2'b00;
      cur_lane    <= 2'b00;
      cur_wdata   <= 32'h0000_0000;
      if_ack      <= 1'b0;
      ls_ack      <= 1'b0;
      ls_err      <= 1'b0;
      ram_ce      <= 1'b0;
      ram_rd      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_addr    <= 8'h00;
      ram_wdata   <= 32'h0000_0000;
      if_data     <= 32'h0000_0000;
      ls_rdata    <= 32'h0000_0000;
      busy        <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      ls_err <= 1'b0;
      ram_ce <= 1'b0;
      ram_rd <= 1'b0;
      ram_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            prefer_data <= 1'b0;
            cur_fetch   <= 1'b0;
            cur_wr      <= iLS_WR;
            cur_size    <= iLS_SIZE;
            cur_lane    <= iLS_ADDR[1:0];
            cur_wdata   <= iLS_WDATA;
            ram_addr    <= iLS_ADDR[9:2];
            busy        <= 1'b1;
            if (ls_illegal) begin
              state  <= ERR;
              ls_ack <= 1'b1;
              ls_err <= 1'b1;
            end else if (iLS_WR && (iLS_SIZE == 2'b10)) begin
              state     <= WRITE;
              ram_ce    <= 1'b1;
              ram_wr    <= 1'b1;
              ram_wdata <= iLS_WDATA;
              ls_ack    <= 1'b1;
            end else begin
              state  <= READ;
              ram_ce <= 1'b1;
              ram_rd <= 1'b1;
            end
          end else if (grant_fetch) begin
            prefer_data <= 1'b1;
            cur_fetch   <= 1'b1;
            cur_wr      <= 1'b0;
            ram_addr    <= iIF_ADDR;
            busy        <= 1'b1;
            state       <= READ;
            ram_ce      <= 1'b1;
            ram_rd      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          state <= RESP;
          if (cur_fetch) begin
            if_ack <= 1'b1;
          end else if (!cur_wr) begin
            ls_ack <= 1'b1;
          end else begin
            if_ack <= 1'b0;
          end
        end
        RESP: begin
          if (cur_fetch) begin
            if_data <= iRAM_DATA;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (!cur_wr) begin
            ls_rdata <= iRAM_DATA;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            ram_wdata <= merge_word(iRAM_DATA, cur_wdata, cur_size, cur_lane);
            ram_ce    <= 1'b1;
            ram_wr    <= 1'b1;
            ls_ack    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a synchronous RAM model, scoreboards for fetch
// responses, load/store responses and RAM writes, and directed vectors.
module tb_ram_arbiter;

  logic        iCLK;
  logic        iRST_N;
  logic        iIF_REQ;
  logic [7:0]  iIF_ADDR;
  logic        oIF_ACK;
  logic [31:0] oIF_DATA;
  logic        iLS_REQ;
  logic        iLS_WR;
  logic [1:0]  iLS_SIZE;
  logic [9:0]  iLS_ADDR;
  logic [31:0] iLS_WDATA;
  logic        oLS_ACK;
  logic        oLS_ERR;
  logic [31:0] oLS_RDATA;
  logic        oRAM_CE;
  logic        oRAM_RD;
  logic        oRAM_WR;
  logic [7:0]  oRAM_ADDR;
  logic [31:0] oRAM_WDATA;
  logic [31:0] iRAM_DATA;
  logic        oBUSY;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } ls_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic [31:0] if_q[$];
  ls_exp_t     ls_q[$];
  wr_exp_t     wr_q[$];

  logic [31:0] mem [0:255];
  logic [31:0] ram_q;
  int          cyc;
  int          total;
  int          bad;

  ram_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iIF_REQ(iIF_REQ), .iIF_ADDR(iIF_ADDR), .oIF_ACK(oIF_ACK), .oIF_DATA(oIF_DATA),
    .iLS_REQ(iLS_REQ), .iLS_WR(iLS_WR), .iLS_SIZE(iLS_SIZE), .iLS_ADDR(iLS_ADDR),
    .iLS_WDATA(iLS_WDATA), .oLS_ACK(oLS_ACK), .oLS_ERR(oLS_ERR), .oLS_RDATA(oLS_RDATA),
    .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR), .oRAM_ADDR(oRAM_ADDR),
    .oRAM_WDATA(oRAM_WDATA), .iRAM_DATA(iRAM_DATA), .oBUSY(oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Synchronous RAM: read data appears the cycle after the RD strobe.
  assign iRAM_DATA = ram_q;
  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    if (oRAM_CE && oRAM_RD) ram_q <= mem[oRAM_ADDR];
    if (oRAM_CE && oRAM_WR) mem[oRAM_ADDR] <= oRAM_WDATA;
  end

  // Response and write scoreboards, sampled mid-cycle.
  always @(negedge iCLK) begin
    check("rd_wr_excl", 32'(oRAM_RD & oRAM_WR), 32'h0);
    if (oIF_ACK) begin
      if (if_q.size() == 0) check("if_unexp", 32'h1, 32'h0);
      else check("if_data", oIF_DATA, if_q.pop_front());
    end
    if (oLS_ACK) begin
      if (ls_q.size() == 0) check("ls_unexp", 32'h1, 32'h0);
      else begin
        ls_exp_t e;
        e = ls_q.pop_front();
        check("ls_err", 32'(oLS_ERR), 32'(e.err));
        if (e.err) check("err_strobes", {29'h0, oRAM_CE, oRAM_RD, oRAM_WR}, 32'h0);
        if (e.chk) check("ls_rdata", oLS_RDATA, e.data);
      end
    end
    if (oRAM_CE && oRAM_WR) begin
      if (wr_q.size() == 0) check("wr_unexp", 32'h1, 32'h0);
      else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        check("wr_addr", 32'(oRAM_ADDR), 32'(w.addr));
        check("wr_data", oRAM_WDATA, w.data);
      end
    end
  end

  task automatic do_fetch(input logic [7:0] addr, input int exp_lat, output int ack_cyc);
    int   start;
    logic got;
    @(posedge iCLK); #1;
    iIF_REQ  = 1'b1;
    iIF_ADDR = addr;
    if_q.push_back(mem[addr]);
    start = cyc;
    got   = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge iCLK);
      got = oIF_ACK;
    end
    ack_cyc = cyc;
    if (!got) check("if_timeout", 32'h0, 32'h1);
    if (exp_lat >= 0) check("if_lat", 32'(ack_cyc - start), 32'(exp_lat));
    @(posedge iCLK); #1;
    iIF_REQ = 1'b0;
  endtask

  task automatic do_ls(input logic wr, input logic [1:0] size, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                       input logic exp_wr, input logic [7:0] exp_waddr, input logic [31:0] exp_wdata,
                       input int exp_lat, output int ack_cyc);
    int      start;
    logic    got;
    ls_exp_t e;
    wr_exp_t w;
    @(posedge iCLK); #1;
    iLS_REQ   = 1'b1;
    iLS_WR    = wr;
    iLS_SIZE  = size;
    iLS_ADDR  = addr;
    iLS_WDATA = wdata;
    e.err  = exp_err;
    e.chk  = !wr && !exp_err;
    e.data = exp_rdata;
    ls_q.push_back(e);
    if (exp_wr) begin
      w.addr = exp_waddr;
      w.data = exp_wdata;
      wr_q.push_back(w);
    end
    start = cyc;
    got   = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge iCLK);
      got = oLS_ACK;
    end
    ack_cyc = cyc;
    if (!got) check("ls_timeout", 32'h0, 32'h1);
    if (exp_lat >= 0) check("ls_lat", 32'(ack_cyc - start), 32'(exp_lat));
    @(posedge iCLK); #1;
    iLS_REQ = 1'b0;
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_strobes"}, {29'h0, oRAM_CE, oRAM_RD, oRAM_WR}, 32'h0);
    check({tag, "_acks"}, {28'h0, oIF_ACK, oLS_ACK, oLS_ERR, oBUSY}, 32'h0);
    check({tag, "_ifdata"}, oIF_DATA, 32'h0);
    check({tag, "_lsdata"}, oLS_RDATA, 32'h0);
    check({tag, "_addr"}, 32'(oRAM_ADDR), 32'h0);
    check({tag, "_wdata"}, oRAM_WDATA, 32'h0);
  endtask

  initial begin
    int a, b;
    total = 0;
    bad   = 0;
    cyc   = 0;
    ram_q = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5500_0000 | i;
    mem[8'h00] = 32'hCAFE_0000;
    mem[8'h01] = 32'h1122_3344;
    mem[8'h02] = 32'h1122_3344;
    mem[8'h10] = 32'h00C0_FFEE;
    mem[8'h20] = 32'h2020_2020;
    mem[8'hFF] = 32'h0102_0304;
    iRST_N = 1'b0; iIF_REQ = 1'b0; iIF_ADDR = 8'h00;
    iLS_REQ = 1'b0; iLS_WR = 1'b0; iLS_SIZE = 2'b00; iLS_ADDR = 10'h000; iLS_WDATA = 32'h0;
    #3;
    reset_outputs_zero("rst");
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;

    // Basic fetch, data holding after ACK, top address.
    do_fetch(8'h10, 2, a);
    @(negedge iCLK);
    check("if_hold", oIF_DATA, 32'h00C0_FFEE);
    check("idle_busy", 32'(oBUSY), 32'h0);
    do_fetch(8'hFF, 2, a);

    // Ties: data first out of reset, then alternation.
    fork
      do_fetch(8'h20, -1, a);
      do_ls(1'b0, 2'b10, 10'h000, 32'h0, 1'b0, 32'hCAFE_0000, 1'b0, 8'h00, 32'h0, 2, b);
    join
    check("tie1_data_first", 32'(b < a), 32'h1);
    fork
      do_fetch(8'h20, -1, a);
      do_ls(1'b0, 2'b10, 10'h000, 32'h0, 1'b0, 32'hCAFE_0000, 1'b0, 8'h00, 32'h0, -1, b);
    join
    check("tie2_data_first", 32'(b < a), 32'h1);
    do_ls(1'b0, 2'b10, 10'h004, 32'h0, 1'b0, 32'h1122_3344, 1'b0, 8'h00, 32'h0, 2, b);
    fork
      do_fetch(8'h10, -1, a);
      do_ls(1'b0, 2'b10, 10'h000, 32'h0, 1'b0, 32'hCAFE_0000, 1'b0, 8'h00, 32'h0, -1, b);
    join
    check("tie3_fetch_first", 32'(a < b), 32'h1);

    // Stores: byte and half read-modify-write, full word, then read back.
    do_ls(1'b1, 2'b00, 10'h006, 32'h0000_00AB, 1'b0, 32'h0, 1'b1, 8'h01, 32'h11AB_3344, 3, b);
    do_ls(1'b0, 2'b10, 10'h004, 32'h0, 1'b0, 32'h11AB_3344, 1'b0, 8'h00, 32'h0, 2, b);
    do_ls(1'b1, 2'b01, 10'h00A, 32'h0000_BEEF, 1'b0, 32'h0, 1'b1, 8'h02, 32'hBEEF_3344, 3, b);
    do_ls(1'b1, 2'b10, 10'h00C, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 8'h03, 32'hDEAD_BEEF, 1, b);
    do_ls(1'b0, 2'b10, 10'h00C, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'h0, 2, b);
    do_ls(1'b1, 2'b00, 10'h3FF, 32'h0000_005A, 1'b0, 32'h0, 1'b1, 8'hFF, 32'h5A02_0304, 3, b);
    do_ls(1'b0, 2'b10, 10'h3FC, 32'h0, 1'b0, 32'h5A02_0304, 1'b0, 8'h00, 32'h0, 2, b);

    // Illegal accesses.
    do_ls(1'b0, 2'b10, 10'h003, 32'h0, 1'b1, 32'h0, 1'b0, 8'h00, 32'h0, 1, b);
    do_ls(1'b1, 2'b01, 10'h001, 32'h1234, 1'b1, 32'h0, 1'b0, 8'h00, 32'h0, 1, b);
    do_ls(1'b0, 2'b11, 10'h000, 32'h0, 1'b1, 32'h0, 1'b0, 8'h00, 32'h0, 1, b);
    do_ls(1'b1, 2'b10, 10'h002, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 8'h00, 32'h0, 1, b);

    // Reset in the WRITE cycle of a sub-word store aborts it.
    @(posedge iCLK); #1;
    iLS_REQ = 1'b1; iLS_WR = 1'b1; iLS_SIZE = 2'b00; iLS_ADDR = 10'h010; iLS_WDATA = 32'h77;
    repeat (3) @(posedge iCLK);
    #1;
    check("pre_rst_write", 32'(oRAM_WR), 32'h1);
    iRST_N = 1'b0;
    #1;
    reset_outputs_zero("midrst");
    iLS_REQ = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    check("midrst_mem", mem[8'h04], 32'h5500_0004);

    // Normal operation resumes from IDLE.
    do_fetch(8'h10, 2, a);
    do_ls(1'b1, 2'b00, 10'h010, 32'h0000_0077, 1'b0, 32'h0, 1'b1, 8'h04, 32'h5500_0077, 3, b);

    repeat (3) @(negedge iCLK);
    check("if_q_empty", 32'(if_q.size()), 32'h0);
    check("ls_q_empty", 32'(ls_q.size()), 32'h0);
    check("wr_q_empty", 32'(wr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
